// File: rtl/gcd_sched_pkg.sv
// rtl/gcd_sched_pkg.sv - shared types and helpers for the gcd round-robin scheduler
package gcd_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_e;

    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational rotating-priority one-hot arbiter
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id
);

    logic            found;
    logic [ID_W-1:0] idx;

    // Search starts at ptr and wraps, so the requester after the last owner wins ties.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = ID_W'((32'(ptr) + 32'(i)) % 32'(N_REQ));
            if (!found && req[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = idx;
            end
        end
    end

endmodule

// File: rtl/gcd_rr_sched.sv
// rtl/gcd_rr_sched.sv - round-robin scheduler sharing one gcd core among N_REQ requesters
module gcd_rr_sched
    import gcd_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int OP_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        i_req_valid,
    input  logic [N_REQ*OP_W-1:0]   i_req_a,
    input  logic [N_REQ*OP_W-1:0]   i_req_b,
    output logic [N_REQ-1:0]        o_req_ready,
    output logic [N_REQ-1:0]        o_rsp_valid,
    output logic [OP_W-1:0]         o_rsp_gcd,
    output logic                    o_rsp_err,
    input  logic [N_REQ-1:0]        i_rsp_ready,
    output logic [OP_W-1:0]         o_core_a,
    output logic [OP_W-1:0]         o_core_b,
    output logic                    o_core_valid,
    input  logic                    i_core_ready,
    input  logic [OP_W-1:0]         i_core_gcd,
    input  logic                    i_core_valid,
    output logic                    o_core_ready,
    output logic                    o_core_flush,
    output logic                    o_busy
);

    localparam int ID_W = $clog2(N_REQ);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    sched_state_e    state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] owner_q, owner_d;
    logic [OP_W-1:0] a_q, a_d;
    logic [OP_W-1:0] b_q, b_d;
    logic [OP_W-1:0] res_q, res_d;
    logic            err_q, err_d;
    logic            flush_q, flush_d;
    logic [WD_W-1:0] wd_q, wd_d;

    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_id;
    logic [OP_W-1:0]  req_a_sel, req_b_sel;

    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .req      (i_req_valid),
        .ptr      (ptr_q),
        .grant    (grant),
        .grant_id (grant_id)
    );

    always_comb begin
        req_a_sel = '0;
        req_b_sel = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant[k]) begin
                req_a_sel = i_req_a[k*OP_W +: OP_W];
                req_b_sel = i_req_b[k*OP_W +: OP_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            flush_q <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            err_q   <= err_d;
            flush_q <= flush_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        err_d   = err_q;
        flush_d = 1'b0;
        wd_d    = wd_q;
        unique case (state_q)
            IDLE: begin
                if (|grant) begin
                    owner_d = grant_id;
                    a_d     = req_a_sel;
                    b_d     = req_b_sel;
                    // A zero operand makes the gcd trivially the other one; skip the core.
                    if (req_a_sel == '0 || req_b_sel == '0) begin
                        res_d   = req_a_sel | req_b_sel;
                        err_d   = 1'b0;
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (i_core_ready) begin
                    wd_d    = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                wd_d = wd_q + 1'b1;
                if (i_core_valid) begin
                    res_d   = i_core_gcd;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    flush_d = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (i_rsp_ready[owner_q]) begin
                    ptr_d   = ID_W'(rr_next(32'(owner_q), N_REQ));
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_rsp_valid = '0;
        if (state_q == RESP) begin
            o_rsp_valid[owner_q] = 1'b1;
        end
    end

    assign o_req_ready  = (state_q == IDLE) ? grant : '0;
    assign o_rsp_gcd    = res_q;
    assign o_rsp_err    = err_q & (state_q == RESP);
    assign o_core_a     = a_q;
    assign o_core_b     = b_q;
    assign o_core_valid = (state_q == ISSUE);
    assign o_core_ready = (state_q == WAIT);
    assign o_core_flush = flush_q;
    assign o_busy       = (state_q != IDLE);

endmodule

// File: doc/gcd_rr_sched.md
# gcd_rr_sched

Round-robin scheduler that shares one `gcd` calculator core among `N_REQ` independent requesters. Each requester submits an operand pair over a valid/ready handshake. The scheduler grants one job at a time, sequences the core's input and output handshakes, and routes the result back to the owning requester. It also short-circuits zero operands and recovers from a hung core with a watchdog that flushes the core. It sits between requester masters (DMA, APB wrappers, CPU ports) and a single `gcd` instance.

## Interface
- `N_REQ`, 4, number of requesters (2..16)
- `OP_W`, 8, operand/result width
- `TIMEOUT`, 255, max cycles allowed in WAIT before flush (≥1)
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `i_req_valid`  in  N_REQ  per-requester job valid
- `i_req_a`  in  N_REQ*OP_W  operand a; requester k on bits [k*OP_W +: OP_W]
- `i_req_b`  in  N_REQ*OP_W  operand b; same packing as `i_req_a`
- `o_req_ready`  out  N_REQ  one-hot accept
- `o_rsp_valid`  out  N_REQ  one-hot result valid
- `o_rsp_gcd`  out  OP_W  result, shared bus, meaningful only when `o_rsp_valid` is non-zero
- `o_rsp_err`  out  1  qualifies `o_rsp_valid`: result produced by timeout
- `i_rsp_ready`  in  N_REQ  per-requester result accept
- `o_core_a`, `o_core_b`  out  OP_W each  operands to core
- `o_core_valid`  out  1  core input valid
- `i_core_ready`  in  1  core input ready
- `i_core_gcd`  in  OP_W  core result
- `i_core_valid`  in  1  core result valid
- `o_core_ready`  out  1  core result ready
- `o_core_flush`  out  1  one-cycle pulse; core reset request
- `o_busy`  out  1  state ≠ IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant = first k with `i_req_valid[k]`, searching from `ptr_rg` upward with wrap.
  - `o_req_ready` = one-hot grant, combinational, asserted only in IDLE.
  - On transfer (valid & ready): latch `a`, `b` and owner id.
  - If `a==0` or `b==0`: result = `a|b` (so gcd(0,0)=0), `err_rg`=0, go to RESP; the core is not used.
  - Otherwise go to ISSUE.
- ISSUE: `o_core_valid`=1 with latched operands, held stable until `i_core_ready`, then go to WAIT.
- WAIT:
  - `o_core_ready`=1. On `i_core_valid`: latch `i_core_gcd`, `err_rg`=0, go to RESP.
  - Watchdog counter (width `$clog2(TIMEOUT+1)`) clears on entry and increments each WAIT cycle. When it reaches `TIMEOUT` without `i_core_valid`: pulse `o_core_flush`, result=0, `err_rg`=1, go to RESP.
  - If `i_core_valid` arrives in the expiry cycle, the valid result wins and there is no flush.
- RESP:
  - `o_rsp_valid[owner]`=1, `o_rsp_gcd`/`o_rsp_err` held stable until `i_rsp_ready[owner]`.
  - On accept: `ptr_rg` = (owner+1) mod `N_REQ`, go to IDLE.
  - `i_rsp_ready` of non-owners is ignored.
- One job in flight; no new grant until RESP completes.
- Requesters must hold valid/operands until ready; dropping valid before grant is legal (no transfer).
- Reset values: state IDLE, `ptr_rg`=0, all outputs 0.
- Reset asserted mid-job discards the job with no response. It does not pulse `o_core_flush`; the core is reset by the system reset.

## Timing
- `o_req_ready` is combinational from `i_req_valid` and `ptr_rg`. All other outputs are registered or decoded from state and registers.
- Zero-operand job: transfer at cycle T, `o_rsp_valid` at T+1.
- Core job: transfer T, `o_core_valid` T+1, earliest `o_core_ready` T+2. Result latched on the `i_core_valid` cycle; `o_rsp_valid` the next cycle.
- Response accepted at cycle R: earliest next grant at R+1. Back-to-back throughput for zero jobs is one job per 2 cycles (IDLE, RESP).
- Flush pulse coincides with the RESP entry edge: exactly 1 cycle, `TIMEOUT` cycles after WAIT entry.

## Structure
- Package `gcd_sched_pkg`: `sched_state_e` enum {IDLE, ISSUE, WAIT, RESP} and the function `rr_next(ptr, n)`.
- Sub-module `rr_arbiter`: combinational rotating-priority one-hot grant, parameterised by `N_REQ`, with inputs `req` and `ptr` and outputs `grant` and `grant_id`.
- Top: FSM, operand/result/owner registers, watchdog counter, output decode.

## Test plan
- Single requester 0, a=48, b=18, core model with 5-cycle latency -> `o_rsp_valid`=4'b0001, `o_rsp_gcd`=6, `o_rsp_err`=0, `ptr_rg`→1.
- All 4 requesters valid continuously, each pair (12,8) -> grants in order 0,1,2,3,0; every response is 4; no requester starved.
- Requester 2, a=0, b=35 -> response 35 at T+1, `o_core_valid` never asserted; a=0, b=0 -> response 0.
- Core model never asserts `i_core_valid`, `TIMEOUT`=10 -> `o_core_flush` is a 1-cycle pulse 10 cycles after WAIT entry; response gcd=0, err=1; the next job completes normally.
- Hold `i_rsp_ready`=0 for 7 cycles, plus stall `i_core_ready` for 3 cycles -> `o_rsp_gcd` and `o_core_a`/`o_core_b` stable throughout; no second grant.
- Assert `rst` in WAIT -> all outputs 0 asynchronously, no response issued; after release, requester 1 is served first when 1 and 3 are both valid.
